// File: rtl/timer_pkg.sv
// Shared state encoding and default sizing for the timer sequencer and its watchdog.
package timer_pkg;

    localparam int          STATE_W            = 2;
    localparam int          REPEAT_W_DEFAULT   = 8;
    localparam int          WDOG_W_DEFAULT     = 32;
    localparam logic [31:0] WDOG_LIMIT_DEFAULT = 32'h8000_0000;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/timer_watchdog.sv
// Saturating cycle counter guarding one timer period; flags expiry at LIMIT-1.
module timer_watchdog import timer_pkg::*; #(
    parameter int                WDOG_W = WDOG_W_DEFAULT,
    parameter logic [WDOG_W-1:0] LIMIT  = WDOG_W'(WDOG_LIMIT_DEFAULT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST = LIMIT - WDOG_W'(1);

    logic [WDOG_W-1:0] count;

    // Count enabled cycles, holding at the expiry value rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/timer_sequencer.sv
// Drives a timer through a programmable number of back-to-back periods,
// watching each period with a watchdog and reporting completion or stalls.
module timer_sequencer import timer_pkg::*; #(
    parameter int                REPEAT_W   = REPEAT_W_DEFAULT,
    parameter int                WDOG_W     = WDOG_W_DEFAULT,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_LIMIT_DEFAULT)
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                run_i,
    input  logic                abort_i,
    input  logic [REPEAT_W-1:0] repeats_i,
    output logic                timer_start_o,
    input  logic                timer_done_i,
    output logic                busy_o,
    output logic                period_done_o,
    output logic                seq_done_o,
    output logic                error_o,
    output logic [REPEAT_W-1:0] remaining_o
);

    seq_state_e          state;
    seq_state_e          next_state;
    logic                armed;
    logic                armed_d;
    logic                start_d;
    logic                busy_d;
    logic                period_done_d;
    logic                seq_done_d;
    logic                error_d;
    logic [REPEAT_W-1:0] remaining_d;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    timer_watchdog #(
        .WDOG_W (WDOG_W),
        .LIMIT  (WDOG_LIMIT)
    ) u_watchdog (
        .clk     (clk_i),
        .rst_n   (arst_ni),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and next-output decisions; a done level only counts once a low has been seen, and abort overrides all.
    always_comb begin
        next_state    = state;
        armed_d       = armed;
        start_d       = 1'b0;
        busy_d        = 1'b0;
        period_done_d = 1'b0;
        seq_done_d    = 1'b0;
        error_d       = error_o;
        remaining_d   = remaining_o;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;

        case (state)
            IDLE: begin
                if (run_i && (repeats_i != '0)) begin
                    remaining_d = repeats_i;
                    error_d     = 1'b0;
                    next_state  = ARM;
                end
            end
            ARM: begin
                wd_clear   = 1'b1;
                armed_d    = 1'b0;
                next_state = WAIT;
            end
            WAIT: begin
                wd_enable = 1'b1;
                if (!timer_done_i) begin
                    armed_d = 1'b1;
                end
                if (armed && timer_done_i) begin
                    period_done_d = 1'b1;
                    if (remaining_o != '0) begin
                        remaining_d = remaining_o - REPEAT_W'(1);
                    end
                    next_state = (remaining_o <= REPEAT_W'(1)) ? DONE : ARM;
                end else if (wd_expired) begin
                    error_d    = 1'b1;
                    next_state = IDLE;
                end
            end
            DONE: begin
                seq_done_d = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (abort_i) begin
            next_state    = IDLE;
            period_done_d = 1'b0;
            seq_done_d    = 1'b0;
            remaining_d   = '0;
            error_d       = error_o;
        end

        start_d = (next_state == ARM);
        busy_d  = (next_state != IDLE);
    end

    // Registered outputs and the stale-done qualifier.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            timer_start_o <= 1'b0;
            busy_o        <= 1'b0;
            period_done_o <= 1'b0;
            seq_done_o    <= 1'b0;
            error_o       <= 1'b0;
            remaining_o   <= '0;
            armed         <= 1'b0;
        end else begin
            timer_start_o <= start_d;
            busy_o        <= busy_d;
            period_done_o <= period_done_d;
            seq_done_o    <= seq_done_d;
            error_o       <= error_d;
            remaining_o   <= remaining_d;
            armed         <= armed_d;
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_timer_sequencer;

    localparam int LIMIT = 16;

    logic       clk_i = 1'b0;
    logic       arst_ni = 1'b1;
    logic       run_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] repeats_i = 8'd0;
    logic       timer_start_o;
    logic       timer_done_i = 1'b0;
    logic       busy_o;
    logic       period_done_o;
    logic       seq_done_o;
    logic       error_o;
    logic [7:0] remaining_o;

    int tests_run = 0;
    int tests_failed = 0;

    // model of what the outputs must be in the current cycle
    bit exp_start = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_pd = 1'b0;
    bit exp_sd = 1'b0;
    bit exp_err = 1'b0;
    int exp_rem = 0;
    bit m_waiting = 1'b0;
    bit m_finishing = 1'b0;
    bit m_saw_low = 1'b0;
    int m_age = 0;

    // observed pulse counts for directed checks
    int cnt_start = 0;
    int cnt_pd = 0;
    int cnt_sd = 0;
    int rem_log[$];

    // behavioural timer controls
    bit timer_auto = 1'b0;
    bit rand_timer = 1'b0;
    int fix_delay = 5;
    int fix_stale = 0;
    int cur_delay = 5;
    int cur_stale = 0;
    int tcount = 100;

    timer_sequencer #(
        .REPEAT_W   (8),
        .WDOG_W     (32),
        .WDOG_LIMIT (32'd16)
    ) dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .run_i         (run_i),
        .abort_i       (abort_i),
        .repeats_i     (repeats_i),
        .timer_start_o (timer_start_o),
        .timer_done_i  (timer_done_i),
        .busy_o        (busy_o),
        .period_done_o (period_done_o),
        .seq_done_o    (seq_done_o),
        .error_o       (error_o),
        .remaining_o   (remaining_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit run, input logic [7:0] reps, input bit abort);
        @(negedge clk_i);
        run_i     = run;
        repeats_i = reps;
        abort_i   = abort;
    endtask

    task automatic wait_seq_done(input string name, input int budget);
        int n = 0;
        while (seq_done_o !== 1'b1 && n < budget) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            n++;
        end
        checkOutput(name, 32'(seq_done_o), 32'd1);
    endtask

    task automatic model_reset();
        exp_start   = 1'b0;
        exp_busy    = 1'b0;
        exp_pd      = 1'b0;
        exp_sd      = 1'b0;
        exp_err     = 1'b0;
        exp_rem     = 0;
        m_waiting   = 1'b0;
        m_finishing = 1'b0;
        m_saw_low   = 1'b0;
        m_age       = 0;
    endtask

    // One clock of the sequence rules: start cycle, waiting period, finishing, idle acceptance.
    task automatic model_step();
        bit n_start = 1'b0;
        bit n_pd = 1'b0;
        bit n_sd = 1'b0;
        if (abort_i) begin
            m_waiting   = 1'b0;
            m_finishing = 1'b0;
            exp_rem     = 0;
        end else if (exp_start) begin
            m_waiting = 1'b1;
            m_age     = 0;
            m_saw_low = 1'b0;
        end else if (m_waiting) begin
            if (m_saw_low && timer_done_i) begin
                n_pd      = 1'b1;
                m_waiting = 1'b0;
                if (exp_rem > 0) exp_rem--;
                if (exp_rem == 0) m_finishing = 1'b1;
                else n_start = 1'b1;
            end else if (m_age == LIMIT - 1) begin
                exp_err   = 1'b1;
                m_waiting = 1'b0;
            end else begin
                m_age++;
                if (!timer_done_i) m_saw_low = 1'b1;
            end
        end else if (m_finishing) begin
            m_finishing = 1'b0;
            n_sd        = 1'b1;
        end else if (run_i && repeats_i != 8'd0) begin
            exp_rem = int'(repeats_i);
            exp_err = 1'b0;
            n_start = 1'b1;
        end
        exp_start = n_start;
        exp_pd    = n_pd;
        exp_sd    = n_sd;
        exp_busy  = n_start || m_waiting || m_finishing;
    endtask

    // Advance the model on each edge and compare every output just after it.
    always @(posedge clk_i) begin
        if (!arst_ni) model_reset();
        else model_step();
        #1;
        if (timer_start_o === 1'b1) cnt_start++;
        if (period_done_o === 1'b1) begin
            cnt_pd++;
            rem_log.push_back(int'(remaining_o));
        end
        if (seq_done_o === 1'b1) cnt_sd++;
        checkOutput("cyc_start", 32'(timer_start_o), 32'(exp_start));
        checkOutput("cyc_busy", 32'(busy_o), 32'(exp_busy));
        checkOutput("cyc_period_done", 32'(period_done_o), 32'(exp_pd));
        checkOutput("cyc_seq_done", 32'(seq_done_o), 32'(exp_sd));
        checkOutput("cyc_error", 32'(error_o), 32'(exp_err));
        checkOutput("cyc_remaining", 32'(remaining_o), 32'(exp_rem));
    end

    // Behavioural timer: restarts on start, may keep a stale level briefly, raises done after a delay.
    always @(negedge clk_i) begin
        if (timer_auto) begin
            if (timer_start_o) begin
                tcount = 0;
                if (rand_timer) begin
                    cur_delay = int'($urandom_range(0, 8));
                    cur_stale = int'($urandom_range(0, 2));
                end else begin
                    cur_delay = fix_delay;
                    cur_stale = fix_stale;
                end
            end else if (tcount < 1000) begin
                tcount++;
            end
            if (tcount >= cur_stale) timer_done_i = (cur_delay != 0) && (tcount >= cur_delay);
        end
    end

    task automatic clear_counts();
        cnt_start = 0;
        cnt_pd    = 0;
        cnt_sd    = 0;
        rem_log.delete();
    endtask

    initial begin
        #1 arst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        arst_ni = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("rst_start", 32'(timer_start_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_error", 32'(error_o), 32'd0);
        checkOutput("rst_remaining", 32'(remaining_o), 32'd0);

        // three periods, timer done five cycles after each start
        fix_delay  = 5;
        fix_stale  = 0;
        timer_auto = 1'b1;
        clear_counts();
        applyStimulus(1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t1_start_latency", 32'(timer_start_o), 32'd1);
        checkOutput("t1_remaining_latched", 32'(remaining_o), 32'd3);
        wait_seq_done("t1_seq_done", 100);
        checkOutput("t1_busy_after", 32'(busy_o), 32'd0);
        checkOutput("t1_start_count", 32'(cnt_start), 32'd3);
        checkOutput("t1_pd_count", 32'(cnt_pd), 32'd3);
        checkOutput("t1_sd_count", 32'(cnt_sd), 32'd1);
        checkOutput("t1_error", 32'(error_o), 32'd0);
        checkOutput("t1_rem_log_size", 32'(rem_log.size()), 32'd3);
        if (rem_log.size() == 3) begin
            for (int i = 0; i < 3; i++) checkOutput("t1_rem_step", 32'(rem_log[i]), 32'(2 - i));
        end

        // stale done level must not count until a low has been seen
        timer_auto = 1'b0;
        clear_counts();
        applyStimulus(1'b1, 8'd1, 1'b0);
        timer_done_i = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t2_start", 32'(timer_start_o), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        timer_done_i = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0);
        timer_done_i = 1'b1;
        checkOutput("t2_no_early_pd", 32'(cnt_pd), 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t2_pd_on_rise", 32'(period_done_o), 32'd1);
        checkOutput("t2_busy_in_done", 32'(busy_o), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t2_seq_done", 32'(seq_done_o), 32'd1);
        checkOutput("t2_pd_count", 32'(cnt_pd), 32'd1);

        // watchdog: timer never finishes
        timer_done_i = 1'b0;
        clear_counts();
        applyStimulus(1'b1, 8'd2, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        repeat (16) applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t3_error_not_yet", 32'(error_o), 32'd0);
        checkOutput("t3_busy_before", 32'(busy_o), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t3_error_set", 32'(error_o), 32'd1);
        checkOutput("t3_busy_after", 32'(busy_o), 32'd0);
        checkOutput("t3_remaining_held", 32'(remaining_o), 32'd2);
        checkOutput("t3_no_pd", 32'(cnt_pd), 32'd0);
        checkOutput("t3_no_sd", 32'(cnt_sd), 32'd0);
        applyStimulus(1'b1, 8'd1, 1'b0);
        fix_delay  = 3;
        timer_auto = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t3_error_cleared", 32'(error_o), 32'd0);
        checkOutput("t3_restart", 32'(timer_start_o), 32'd1);
        wait_seq_done("t3_seq_done", 60);

        // abort in period 2 of 4 on the same cycle done is sampled
        timer_auto = 1'b0;
        timer_done_i = 1'b0;
        clear_counts();
        applyStimulus(1'b1, 8'd4, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        timer_done_i = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        timer_done_i = 1'b0;
        checkOutput("t4_pd_first", 32'(period_done_o), 32'd1);
        checkOutput("t4_rem_3", 32'(remaining_o), 32'd3);
        applyStimulus(1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1);
        timer_done_i = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t4_no_pd", 32'(period_done_o), 32'd0);
        checkOutput("t4_busy", 32'(busy_o), 32'd0);
        checkOutput("t4_remaining", 32'(remaining_o), 32'd0);
        checkOutput("t4_error", 32'(error_o), 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t4_no_sd", 32'(cnt_sd), 32'd0);
        checkOutput("t4_pd_count", 32'(cnt_pd), 32'd1);

        // zero repeats ignored; run while busy ignored
        clear_counts();
        applyStimulus(1'b1, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t5_zero_start", 32'(timer_start_o), 32'd0);
        checkOutput("t5_zero_busy", 32'(busy_o), 32'd0);
        fix_delay  = 3;
        timer_auto = 1'b1;
        applyStimulus(1'b1, 8'd2, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t5_start", 32'(timer_start_o), 32'd1);
        repeat (3) applyStimulus(1'b1, 8'd5, 1'b0);
        wait_seq_done("t5_seq_done", 60);
        checkOutput("t5_start_count", 32'(cnt_start), 32'd2);

        // asynchronous reset while the start pulse is out
        applyStimulus(1'b1, 8'd2, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t6_start_before", 32'(timer_start_o), 32'd1);
        #1 arst_ni = 1'b0;
        #1;
        checkOutput("t6_start_async", 32'(timer_start_o), 32'd0);
        checkOutput("t6_busy_async", 32'(busy_o), 32'd0);
        checkOutput("t6_remaining_async", 32'(remaining_o), 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        arst_ni = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t6_idle_after", 32'(busy_o), 32'd0);

        // randomized traffic against the model
        rand_timer = 1'b1;
        timer_auto = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            applyStimulus($urandom_range(0, 5) == 0, 8'($urandom_range(0, 5)), $urandom_range(0, 39) == 0);
        end
        repeat (40) applyStimulus(1'b0, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
